key_sw_input_device: RTL and testbench
======================================

// Module: key_sw_input_device
// PURPOSE
//  Memory-mapped input peripheral that answers processor loads for KEY and SW.
//  Synchronizes and debounces the raw board inputs, and exposes data plus status
//  registers (ready/overrun) so software can poll for changes instead of busy-reading.
//  Sits beside the data memory; its read data joins the processor's load-return mux.
// PARAMETERS
//  DBITS           32           data/address width
//  DEBOUNCE_CYCLES 16'd50000    cycles a synchronized input must be stable before accepted
//  ADDR_KDATA      32'hF0000010 KEY data register (RO)
//  ADDR_SDATA      32'hF0000014 SW data register (RO)
//  ADDR_KCTRL      32'hF0000110 KEY status: bit0 ready, bit2 overrun
//  ADDR_SCTRL      32'hF0000114 SW status: bit0 ready, bit2 overrun
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-low reset
//  memAddr    in   DBITS  load/store address
//  memRdEn    in   1      load request this cycle
//  memWrEn    in   1      store request this cycle
//  memWrData  in   DBITS  store data
//  memRdData  out  DBITS  load data, valid the cycle after memRdEn
//  memRdHit   out  1      1 when memRdData is from this block (same cycle as memRdData)
//  KEY        in   4      raw pushbuttons, active-low, asynchronous
//  SW         in   10     raw switches, asynchronous
// BEHAVIOUR
//  - Reset (reset==0 at posedge): sync flops, debounced state, counters = 0 (KEY sync = 4'hF).
//    Ready and overrun bits = 0. memRdData = 0. memRdHit = 0.
//  - Sync: each input goes through 2 flops. KEY is inverted after sync (pressed = 1).
//  - Debounce, per input group (KEY group, SW group):
//    - Two states, STABLE and COUNTING.
//    - STABLE: sync value == debounced value. Counter holds 0.
//    - In STABLE, sync value != debounced value -> COUNTING, counter = 1.
//    - COUNTING, sync value changes again -> counter restarts at 1.
//    - COUNTING, sync value returns to debounced value -> STABLE, counter = 0.
//    - COUNTING, counter reaches DEBOUNCE_CYCLES -> debounced value <= sync value,
//      raise a 1-cycle change event, go to STABLE.
//    - Counter width = $clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.
//    - Raw edge to data-register update latency = 2 + DEBOUNCE_CYCLES cycles.
//  - Data regs: KDATA = {28'b0, kdeb[3:0]}; SDATA = {22'b0, sdeb[9:0]}.
//  - Status, per group:
//    - change event -> ready <= 1.
//    - Overrun <= 1 when a change event occurs while ready==1 and this cycle is not a
//      clearing read.
//    - Load of the data register (memRdEn && memAddr==ADDR_xDATA) -> ready <= 0.
//    - Change event in the same cycle as a clearing read: the event wins (ready stays 1,
//      no overrun).
//    - Store to xCTRL with memWrData[2]==0 clears overrun. Writing 1 has no effect.
//      Ready is not writable.
//    - Stores to the data registers and to unmapped addresses are ignored.
//  - Read port:
//    - memRdData/memRdHit are registered: sampled at the posedge where memRdEn==1,
//      presented the next cycle.
//    - Status read value = {29'b0, overrun, 1'b0, ready}, using the pre-update value.
//    - Load of an unmapped address -> memRdData = 0, memRdHit = 0.
//    - memRdEn==0 -> memRdHit = 0 next cycle; memRdData holds its previous value.
//  - memRdEn and memWrEn both asserted in one cycle: both are performed.
//  - Reset mid-debounce discards the pending change. No event is produced.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with KEY=4'hE -> all reads return 0.
//    After release, KDATA reads 1 only after 2+DEBOUNCE_CYCLES cycles.
//  - Bounce: DEBOUNCE_CYCLES=4. Toggle SW[0] 0/1 every 2 cycles for 20 cycles, then hold 1.
//    -> SDATA=1 exactly 6 cycles after the final edge. SCTRL reads 32'h1.
//  - Clear-on-read: after a KEY[1] press, read KCTRL -> 1. Read KDATA -> 32'h2.
//    Read KCTRL -> 0.
//  - Overrun: two SW changes with no SDATA read -> SCTRL=32'h5.
//    Store 0 to SCTRL -> 32'h1. Store 32'h4 -> unchanged.
//  - Simultaneous: debounce event lands on the same cycle as an SDATA load
//    -> SCTRL=32'h1 after, overrun 0.
//  - Decode: load 32'hF0000018 -> memRdHit=0, data 0. Store 32'hFF to ADDR_KDATA -> KDATA unchanged.

Source files
------------

// File: rtl/key_sw_input_device.sv
// Memory-mapped KEY/SW input peripheral: two-flop sync, per-group debounce,
// data registers and ready/overrun status answering processor loads.
module key_sw_input_device #(
    parameter int unsigned      DBITS           = 32,
    parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(32'hF000_0010),
    parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(32'hF000_0014),
    parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(32'hF000_0110),
    parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(32'hF000_0114)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] memAddr,
    input  logic             memRdEn,
    input  logic             memWrEn,
    input  logic [DBITS-1:0] memWrData,
    output logic [DBITS-1:0] memRdData,
    output logic             memRdHit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW
);

    localparam int unsigned GW    = 10;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES == 16'd0) ? 1
                                  : $clog2(32'(DEBOUNCE_CYCLES) + 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    // Only memWrData[2] is meaningful (overrun clear on status stores)
    logic unused_wr_bits;
    assign unused_wr_bits = ^{memWrData[DBITS-1:3], memWrData[1:0]};

    // Group 0 is KEY (active-low, zero-extended), group 1 is SW
    for (genvar g = 0; g < 2; g++) begin : g_grp
        localparam logic [GW-1:0]    SYNC_RST  = (g == 0) ? GW'(4'hF) : GW'(0);
        localparam logic [GW-1:0]    INV_MASK  = (g == 0) ? GW'(4'hF) : GW'(0);
        localparam logic [DBITS-1:0] DATA_ADDR = (g == 0) ? ADDR_KDATA : ADDR_SDATA;
        localparam logic [DBITS-1:0] CTRL_ADDR = (g == 0) ? ADDR_KCTRL : ADDR_SCTRL;

        logic [GW-1:0]    raw, sync1, sync2, sval;
        logic [GW-1:0]    deb, deb_n, cand, cand_n;
        logic [CNT_W-1:0] cnt, cnt_n, cnt_try;
        logic [0:0]       state, state_n;
        logic             try_acc, event_c;
        logic             rdy, ovr, rd_clr, ovr_set, ovr_clr;

        assign raw  = (g == 0) ? GW'(KEY) : SW;
        assign sval = sync2 ^ INV_MASK;

        always_ff @(posedge clk) begin
            if (!reset) begin
                sync1 <= SYNC_RST;
                sync2 <= SYNC_RST;
                state <= ST_STABLE;
                cnt   <= '0;
                cand  <= '0;
                deb   <= '0;
            end else begin
                sync1 <= raw;
                sync2 <= sync1;
                state <= state_n;
                cnt   <= cnt_n;
                cand  <= cand_n;
                deb   <= deb_n;
            end
        end

        // Accept a value once it has been seen unchanged for DEBOUNCE_CYCLES samples
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            cand_n  = cand;
            deb_n   = deb;
            event_c = 1'b0;
            cnt_try = '0;
            try_acc = 1'b0;
            case (state)
                ST_STABLE: begin
                    if (sval != deb) begin
                        state_n = ST_COUNTING;
                        cand_n  = sval;
                        cnt_try = CNT_ONE;
                        try_acc = 1'b1;
                    end
                end
                ST_COUNTING: begin
                    if (sval == deb) begin
                        state_n = ST_STABLE;
                        cnt_n   = '0;
                    end else if (sval != cand) begin
                        cand_n  = sval;
                        cnt_try = CNT_ONE;
                        try_acc = 1'b1;
                    end else begin
                        cnt_try = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
                        try_acc = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end
            endcase
            if (try_acc) begin
                if (cnt_try >= CNT_LAST) begin
                    deb_n   = sval;
                    event_c = 1'b1;
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_try;
                end
            end
        end

        // A change event beats a same-cycle clearing read
        assign rd_clr  = memRdEn && (memAddr == DATA_ADDR);
        assign ovr_set = event_c && rdy && !rd_clr;
        assign ovr_clr = memWrEn && (memAddr == CTRL_ADDR) && !memWrData[2];

        always_ff @(posedge clk) begin
            if (!reset) begin
                rdy <= 1'b0;
                ovr <= 1'b0;
            end else begin
                if (event_c)     rdy <= 1'b1;
                else if (rd_clr) rdy <= 1'b0;
                if (ovr_set)      ovr <= 1'b1;
                else if (ovr_clr) ovr <= 1'b0;
            end
        end
    end

    // Registered load return; data holds when no load is requested
    always_ff @(posedge clk) begin
        if (!reset) begin
            memRdData <= '0;
            memRdHit  <= 1'b0;
        end else if (memRdEn) begin
            memRdHit <= 1'b1;
            case (memAddr)
                ADDR_KDATA: memRdData <= DBITS'(g_grp[0].deb[3:0]);
                ADDR_SDATA: memRdData <= DBITS'(g_grp[1].deb);
                ADDR_KCTRL: memRdData <= DBITS'({g_grp[0].ovr, 1'b0, g_grp[0].rdy});
                ADDR_SCTRL: memRdData <= DBITS'({g_grp[1].ovr, 1'b0, g_grp[1].rdy});
                default: begin
                    memRdData <= '0;
                    memRdHit  <= 1'b0;
                end
            endcase
        end else begin
            memRdHit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_sw_input_device.sv
// Bench for key_sw_input_device: directed scenarios plus random traffic,
// every cycle compared against a run-length based reference model.
module tb_key_sw_input_device;

    localparam int DC = 4;
    localparam logic [31:0] A_KD = 32'hF000_0010;
    localparam logic [31:0] A_SD = 32'hF000_0014;
    localparam logic [31:0] A_KC = 32'hF000_0110;
    localparam logic [31:0] A_SC = 32'hF000_0114;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] memAddr = '0;
    logic        memRdEn = 1'b0;
    logic        memWrEn = 1'b0;
    logic [31:0] memWrData = '0;
    logic [31:0] memRdData;
    logic        memRdHit;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;

    int n_tests = 0;
    int n_fail  = 0;

    key_sw_input_device #(.DBITS(32), .DEBOUNCE_CYCLES(16'd4)) dut (
        .clk(clk), .reset(reset), .memAddr(memAddr), .memRdEn(memRdEn),
        .memWrEn(memWrEn), .memWrData(memWrData), .memRdData(memRdData),
        .memRdHit(memRdHit), .KEY(KEY), .SW(SW)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples travel through a 2-deep queue; a value is
    // accepted once it has been the visible value for DC consecutive edges.
    logic [3:0]  kq[$];
    logic [9:0]  sq[$];
    logic [3:0]  m_kdeb, m_klast;
    logic [9:0]  m_sdeb, m_slast;
    int          m_krun, m_srun;
    logic        m_krdy, m_kovr, m_srdy, m_sovr, m_hit;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] ks;
        logic [9:0] ss;
        logic kev, sev, kclr, sclr, kset, sset;
        if (!reset) begin
            kq = '{4'hF, 4'hF};
            sq = '{10'h0, 10'h0};
            m_kdeb = '0; m_klast = '0; m_krun = 0;
            m_sdeb = '0; m_slast = '0; m_srun = 0;
            m_krdy = 1'b0; m_kovr = 1'b0; m_srdy = 1'b0; m_sovr = 1'b0;
            m_hit = 1'b0; m_data = '0;
        end else begin
            ks = ~kq.pop_front();
            kq.push_back(KEY);
            ss = sq.pop_front();
            sq.push_back(SW);
            m_krun = (ks == m_klast) ? m_krun + 1 : 1;
            m_klast = ks;
            m_srun = (ss == m_slast) ? m_srun + 1 : 1;
            m_slast = ss;
            kev = (ks != m_kdeb) && (m_krun >= DC);
            sev = (ss != m_sdeb) && (m_srun >= DC);
            if (memRdEn) begin
                m_hit = 1'b1;
                case (memAddr)
                    A_KD: m_data = {28'b0, m_kdeb};
                    A_SD: m_data = {22'b0, m_sdeb};
                    A_KC: m_data = {29'b0, m_kovr, 1'b0, m_krdy};
                    A_SC: m_data = {29'b0, m_sovr, 1'b0, m_srdy};
                    default: begin m_hit = 1'b0; m_data = '0; end
                endcase
            end else begin
                m_hit = 1'b0;
            end
            kclr = memRdEn && (memAddr == A_KD);
            sclr = memRdEn && (memAddr == A_SD);
            kset = kev && m_krdy && !kclr;
            sset = sev && m_srdy && !sclr;
            if (kev) m_krdy = 1'b1; else if (kclr) m_krdy = 1'b0;
            if (sev) m_srdy = 1'b1; else if (sclr) m_srdy = 1'b0;
            if (kset) m_kovr = 1'b1;
            else if (memWrEn && memAddr == A_KC && !memWrData[2]) m_kovr = 1'b0;
            if (sset) m_sovr = 1'b1;
            else if (memWrEn && memAddr == A_SC && !memWrData[2]) m_sovr = 1'b0;
            if (kev) m_kdeb = ks;
            if (sev) m_sdeb = ss;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_hit", 32'(memRdHit), 32'(m_hit));
        chk("model_data", memRdData, m_data);
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [31:0] a);
        memAddr = a; memRdEn = 1'b1;
        tick();
        memRdEn = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memAddr = a; memWrData = d; memWrEn = 1'b1;
        tick();
        memWrEn = 1'b0;
    endtask

    initial begin
        int hold;
        // reset held with KEY[0] pressed
        KEY = 4'hE; reset = 1'b0;
        rd(A_KD); chk("rst_kdata", memRdData, 32'h0);
        rd(A_KC); chk("rst_kctrl", memRdData, 32'h0);
        rd(A_SC); chk("rst_hit", 32'(memRdHit), 32'h0);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            rd(A_KD);
            chk("kdata_latency", memRdData, (i >= 2 + DC + 1) ? 32'h1 : 32'h0);
        end

        // clear-on-read after a KEY[1] press
        KEY = 4'hF; wait_n(8);
        rd(A_KD); chk("key_release", memRdData, 32'h0);
        KEY = 4'hD; wait_n(8);
        rd(A_KC); chk("kctrl_ready", memRdData, 32'h1);
        rd(A_KD); chk("kdata_key1", memRdData, 32'h2);
        rd(A_KC); chk("kctrl_cleared", memRdData, 32'h0);

        // bounce on SW[0], then hold; event coincides with an SDATA load
        for (int i = 0; i < 10; i++) begin
            SW[0] = (i % 2 == 0);
            wait_n(2);
        end
        SW[0] = 1'b1;
        wait_n(5);
        rd(A_SD); chk("sdata_pre_event", memRdData, 32'h0);
        rd(A_SC); chk("sctrl_simultaneous", memRdData, 32'h1);
        rd(A_SD); chk("sdata_debounced", memRdData, 32'h1);

        // overrun and its store-to-clear
        SW = 10'h003; wait_n(8);
        SW = 10'h007; wait_n(8);
        rd(A_SC); chk("sctrl_overrun", memRdData, 32'h5);
        wr(A_SC, 32'h0);
        rd(A_SC); chk("sctrl_wr0", memRdData, 32'h1);
        wr(A_SC, 32'h4);
        rd(A_SC); chk("sctrl_wr4_a", memRdData, 32'h1);
        SW = 10'h00F; wait_n(8);
        rd(A_SC); chk("sctrl_overrun2", memRdData, 32'h5);
        wr(A_SC, 32'h4);
        rd(A_SC); chk("sctrl_wr4_b", memRdData, 32'h5);

        // decode: unmapped load, store to a read-only data register, idle hold
        rd(32'hF000_0018);
        chk("unmapped_hit", 32'(memRdHit), 32'h0);
        chk("unmapped_data", memRdData, 32'h0);
        wr(A_KD, 32'hFF);
        rd(A_KD); chk("kdata_readonly", memRdData, 32'h2);
        tick();
        chk("idle_hit", 32'(memRdHit), 32'h0);
        chk("idle_hold", memRdData, 32'h2);

        // random traffic, including mid-debounce resets and rd+wr together
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                KEY = 4'($urandom);
                if ($urandom_range(0, 2) == 0) SW = 10'($urandom);
                hold = $urandom_range(1, 9);
            end else begin
                hold--;
            end
            case ($urandom_range(0, 5))
                0: memAddr = A_KD;
                1: memAddr = A_SD;
                2: memAddr = A_KC;
                3: memAddr = A_SC;
                4: memAddr = 32'hF000_0018;
                default: memAddr = $urandom;
            endcase
            memRdEn   = ($urandom_range(0, 1) == 1);
            memWrEn   = ($urandom_range(0, 3) == 0);
            memWrData = $urandom;
            reset     = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset = 1'b1; memRdEn = 1'b0; memWrEn = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
